mem_port_arbiter: RTL and testbench

- Shares the single physical-memory (L2/pmem) port between the instruction-fetch cache (mem1 side) and the data cache (mem2 side) of the pipelined LC-3b.
- Sits below both L1 caches. Each cache sees a private read/write/resp interface.
- Sequences one line transaction at a time through a small FSM; the other requester waits.
- Fixed data-side priority; optional round-robin fairness.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/arb_grant_select.sv | 31 +++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared LC-3b memory-side types used by the L1-to-pmem port arbiter.
// Line type, arbiter FSM states and requester-side identifiers.
package mem_port_arbiter_pkg;

  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

  function automatic arb_state_t serve_state(input arb_side_t side);
    return (side == SIDE_D) ? SERVE_D : SERVE_I;
  endfunction

endpackage

// File: rtl/arb_grant_select.sv
// Combinational winner pick between I-cache and D-cache requests (0 cycles, no backpressure).
// ARB_ROUND_ROBIN_EN: alternate on contention using last_grant; otherwise fixed D priority.
module arb_grant_select
  import mem_port_arbiter_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_side_t last_grant,
  output logic      grant,
  output arb_side_t side
);

  assign grant = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the side that did not win last time goes first.
  always_comb begin
    side = SIDE_D;
    if (i_req && d_req) begin
      side = (last_grant == SIDE_D) ? SIDE_I : SIDE_D;
    end else if (i_req) begin
      side = SIDE_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign side = d_req ? SIDE_D : SIDE_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pmem port between I-cache and D-cache, one line transaction at a time.
// Latency: grant registered (strobes 1 cycle after sample); resp combinational with pmem_resp. Macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  arb_side_t  last_grant;
  arb_side_t  grant_side;
  logic       grant;

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SIDE_I;
    end else if (state == IDLE && grant) begin
      last_grant <= grant_side;
    end
  end
`else
  assign last_grant = SIDE_I;
`endif

  arb_grant_select u_grant_select (
    .i_req      (i_read),
    .d_req      (d_read | d_write),
    .last_grant (last_grant),
    .grant      (grant),
    .side       (grant_side)
  );

  // The strobes themselves hold the latched op; a simultaneous read+write becomes a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= serve_state(grant_side);
            if (grant_side == SIDE_D) begin
              pmem_address <= d_address;
              pmem_wdata   <= d_wdata;
              pmem_write   <= d_write;
              pmem_read    <= ~d_write;
            end else begin
              pmem_address <= i_address;
              pmem_write   <= 1'b0;
              pmem_read    <= 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Responses only reach the side currently being served; pmem_resp in IDLE is dropped.
  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a pmem responder and a queue-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  // Everything observed about one pmem transaction.
  typedef struct packed {
    logic              seen;
    logic [7:0]        waitc;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [LINE_W-1:0] wdata;
    logic              stable;
    logic              early;
    logic              ir;
    logic              dr;
    logic [LINE_W-1:0] irdata;
    logic [LINE_W-1:0] drdata;
    logic [LINE_W-1:0] sent;
    logic              idle;
  } txn_t;

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Plays pmem: waits for a strobe, answers on the lat-th strobe cycle, then looks at the gap cycle.
  // hook 1: move i_address mid-transaction; hook 2: requesters drop their requests mid-transaction.
  task automatic pmem_txn(input int lat, input int hook, output txn_t o);
    int w;
    o = '0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(pmem_read | pmem_write) && w < 20);
    o.waitc = 8'(w);
    if (!(pmem_read | pmem_write)) return;
    o.seen   = 1'b1;
    o.addr   = pmem_address;
    o.rd     = pmem_read;
    o.wr     = pmem_write;
    o.wdata  = pmem_wdata;
    o.stable = 1'b1;
    for (int k = 1; k < lat; k++) begin
      o.early |= i_resp | d_resp;
      if (k == 1 && hook == 1) i_address = 16'h5550;
      if (k == 1 && hook == 2) begin
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      @(negedge clk);
      if (pmem_address !== o.addr || pmem_read !== o.rd || pmem_write !== o.wr || pmem_wdata !== o.wdata)
        o.stable = 1'b0;
    end
    o.early |= i_resp | d_resp;
    o.sent     = rand_line();
    pmem_rdata = o.sent;
    pmem_resp  = 1'b1;
    #1;
    o.ir     = i_resp;
    o.dr     = d_resp;
    o.irdata = i_rdata;
    o.drdata = d_rdata;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    o.idle = !(pmem_read | pmem_write | i_resp | d_resp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    tests_run++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_strobes: got %b want 00", {pmem_read, pmem_write});
    end
    tests_run++;
    if (pmem_address !== '0) begin
      tests_failed++; $display("FAIL reset_addr: got %h want 0", pmem_address);
    end
    tests_run++;
    if (pmem_wdata !== '0) begin
      tests_failed++; $display("FAIL reset_wdata: got %h want 0", pmem_wdata);
    end
    tests_run++;
    if ({i_resp, d_resp} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp});
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    txn_t o;
    i_read = 1'b1;
    i_address = 16'h1230;
    pmem_txn(4, 0, o);
    i_read = 1'b0;
    tests_run++;
    if (o.waitc !== 8'd1) begin
      tests_failed++; $display("FAIL iread_grant_latency: got %0d want 1", o.waitc);
    end
    tests_run++;
    if (o.addr !== 16'h1230) begin
      tests_failed++; $display("FAIL iread_addr: got %h want 1230", o.addr);
    end
    tests_run++;
    if ({o.rd, o.wr} !== 2'b10) begin
      tests_failed++; $display("FAIL iread_strobes: got %b want 10", {o.rd, o.wr});
    end
    tests_run++;
    if (o.stable !== 1'b1 || o.early !== 1'b0) begin
      tests_failed++; $display("FAIL iread_hold: got stable=%b early=%b want 1 0", o.stable, o.early);
    end
    tests_run++;
    if ({o.ir, o.dr} !== 2'b10) begin
      tests_failed++; $display("FAIL iread_resp: got %b want 10", {o.ir, o.dr});
    end
    tests_run++;
    if (o.irdata !== o.sent) begin
      tests_failed++; $display("FAIL iread_rdata: got %h want %h", o.irdata, o.sent);
    end
    tests_run++;
    if (o.idle !== 1'b1) begin
      tests_failed++; $display("FAIL iread_idle_after: got %b want 1", o.idle);
    end
  endtask

  task automatic test_d_write();
    txn_t o;
    logic [LINE_W-1:0] b;
    b = rand_line();
    d_write = 1'b1;
    d_address = 16'h04A0;
    d_wdata = b;
    pmem_txn(2, 0, o);
    d_write = 1'b0;
    tests_run++;
    if (o.waitc !== 8'd1 || o.addr !== 16'h04A0) begin
      tests_failed++; $display("FAIL dwrite_grant: got wait=%0d addr=%h want 1 04a0", o.waitc, o.addr);
    end
    tests_run++;
    if ({o.rd, o.wr} !== 2'b01) begin
      tests_failed++; $display("FAIL dwrite_strobes: got %b want 01", {o.rd, o.wr});
    end
    tests_run++;
    if (o.wdata !== b) begin
      tests_failed++; $display("FAIL dwrite_wdata: got %h want %h", o.wdata, b);
    end
    tests_run++;
    if ({o.ir, o.dr} !== 2'b01 || o.idle !== 1'b1) begin
      tests_failed++; $display("FAIL dwrite_resp: got %b idle=%b want 01 idle=1", {o.ir, o.dr}, o.idle);
    end
  endtask

  task automatic test_contention();
    txn_t o1, o2;
    logic [ADDR_W-1:0] ia, da;
    do_reset();
    ia = 16'($urandom);
    da = 16'($urandom);
    i_read = 1'b1; i_address = ia;
    d_read = 1'b1; d_address = da;
    pmem_txn(2, 0, o1);
    d_read = 1'b0;
    pmem_txn(2, 0, o2);
    i_read = 1'b0;
    tests_run++;
    if ({o1.ir, o1.dr} !== 2'b01 || o1.addr !== da) begin
      tests_failed++; $display("FAIL contend_first: got resp=%b addr=%h want 01 %h", {o1.ir, o1.dr}, o1.addr, da);
    end
    tests_run++;
    if ({o2.ir, o2.dr} !== 2'b10 || o2.addr !== ia || o2.waitc !== 8'd1) begin
      tests_failed++; $display("FAIL contend_second: got resp=%b addr=%h wait=%0d want 10 %h 1", {o2.ir, o2.dr}, o2.addr, o2.waitc, ia);
    end
  endtask

  task automatic test_starvation();
    txn_t o;
    logic [4:0] ord;
    int nd, ni;
`ifdef ARB_ROUND_ROBIN_EN
    ord = 5'b10101;
`else
    ord = 5'b00111;
`endif
    do_reset();
    nd = 0; ni = 0;
    i_read = 1'b1; i_address = 16'h2222;
    d_read = 1'b1; d_address = 16'h3330;
    for (int k = 0; k < 5; k++) begin
      pmem_txn(1 + k % 2, 0, o);
      tests_run++;
      if (o.dr !== ord[k] || o.ir !== !ord[k] || o.addr !== (ord[k] ? 16'h3330 : 16'h2222)) begin
        tests_failed++; $display("FAIL starve_order[%0d]: got d=%b i=%b addr=%h want d=%b", k, o.dr, o.ir, o.addr, ord[k]);
      end
      if (o.dr === 1'b1) nd++;
      if (o.ir === 1'b1) ni++;
      if (nd >= 3) d_read = 1'b0;
      if (ni >= 2) i_read = 1'b0;
    end
    i_read = 1'b0;
    d_read = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int w;
    d_write = 1'b1;
    d_address = 16'h0BC0;
    d_wdata = rand_line();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!pmem_write && w < 10);
    tests_run++;
    if (pmem_write !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_write_up: got %b want 1", pmem_write);
    end
    rst_n = 1'b0;
    pmem_resp = 1'b1;
    #1;
    tests_run++;
    if ({pmem_read, pmem_write, d_resp, i_resp} !== 4'b0000) begin
      tests_failed++; $display("FAIL rstmid_immediate: got %b want 0000", {pmem_read, pmem_write, d_resp, i_resp});
    end
    d_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({d_resp, i_resp} !== 2'b00) begin
      tests_failed++; $display("FAIL rstmid_late_resp: got %b want 00", {d_resp, i_resp});
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    tests_run++;
    if ({pmem_read, pmem_write} !== 2'b00 || pmem_address !== '0) begin
      tests_failed++; $display("FAIL rstmid_idle: got %b addr=%h want 00 0", {pmem_read, pmem_write}, pmem_address);
    end
  endtask

  task automatic test_stale_and_drop();
    txn_t o;
    i_read = 1'b1;
    i_address = 16'h1230;
    pmem_txn(3, 1, o);
    i_read = 1'b0;
    tests_run++;
    if (o.addr !== 16'h1230 || o.stable !== 1'b1 || o.ir !== 1'b1) begin
      tests_failed++; $display("FAIL stale_addr: got addr=%h stable=%b resp=%b want 1230 1 1", o.addr, o.stable, o.ir);
    end
    d_read = 1'b1;
    d_address = 16'h7770;
    pmem_txn(3, 2, o);
    tests_run++;
    if (o.dr !== 1'b1 || o.drdata !== o.sent || o.idle !== 1'b1) begin
      tests_failed++; $display("FAIL drop_still_resp: got resp=%b rdata=%h idle=%b want 1 %h 1", o.dr, o.drdata, o.idle, o.sent);
    end
  endtask

  // Model: pending requests per side; D wins contention unless round-robin says the other side is due.
  task automatic test_random();
    txn_t o;
    bit ip, dp, dw, win_d, last_d;
    logic [ADDR_W-1:0] ia, da, exp_addr;
    logic [LINE_W-1:0] dwd, got_rdata;
    do_reset();
    ip = 0; dp = 0; dw = 0; last_d = 0;
    ia = '0; da = '0; dwd = '0;
    for (int r = 0; r < 40; r++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = 16'($urandom);
        i_read = 1'b1; i_address = ia;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = 16'($urandom); dw = 1'($urandom_range(0, 1)); dwd = rand_line();
        d_read = !dw; d_write = dw; d_address = da; d_wdata = dwd;
      end
      if (ip || dp) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = dp && (!ip || !last_d);
`else
        win_d = dp;
`endif
        pmem_txn(int'($urandom_range(1, 4)), 0, o);
        exp_addr = win_d ? da : ia;
        got_rdata = win_d ? o.drdata : o.irdata;
        tests_run++;
        if ({o.ir, o.dr} !== (win_d ? 2'b01 : 2'b10) || o.addr !== exp_addr) begin
          tests_failed++; $display("FAIL rand_grant[%0d]: got resp=%b addr=%h want d=%b addr=%h", r, {o.ir, o.dr}, o.addr, win_d, exp_addr);
        end
        tests_run++;
        if ({o.rd, o.wr} !== (win_d ? {!dw, dw} : 2'b10) || (win_d && dw && o.wdata !== dwd)) begin
          tests_failed++; $display("FAIL rand_op[%0d]: got rw=%b wdata=%h want wr=%b wdata=%h", r, {o.rd, o.wr}, o.wdata, win_d && dw, dwd);
        end
        tests_run++;
        if (got_rdata !== o.sent || o.waitc !== 8'd1 || o.stable !== 1'b1 || o.early !== 1'b0 || o.idle !== 1'b1) begin
          tests_failed++; $display("FAIL rand_timing[%0d]: got rdata_ok=%b wait=%0d stable=%b early=%b idle=%b want 1 1 1 0 1",
                                   r, got_rdata === o.sent, o.waitc, o.stable, o.early, o.idle);
        end
        last_d = win_d;
        if (win_d) begin
          dp = 0; d_read = 1'b0; d_write = 1'b0;
        end else begin
          ip = 0; i_read = 1'b0;
        end
      end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_starvation();
    test_reset_mid_op();
    test_stale_and_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
